// File: rtl/cdma_seq_pkg.sv
// rtl/cdma_seq_pkg.sv - CDMA register map, status/control bit positions, FSM states and done codes
package cdma_seq_pkg;

  localparam logic [7:0] REG_CR     = 8'h00;
  localparam logic [7:0] REG_SR     = 8'h04;
  localparam logic [7:0] REG_SA     = 8'h18;
  localparam logic [7:0] REG_SA_MSB = 8'h1C;
  localparam logic [7:0] REG_DA     = 8'h20;
  localparam logic [7:0] REG_DA_MSB = 8'h24;
  localparam logic [7:0] REG_BTT    = 8'h28;

  localparam int SR_IDLE_BIT    = 1;
  localparam int SR_ERR_LSB     = 4;
  localparam int SR_ERR_MSB     = 6;
  localparam int SR_IOC_IRQ_BIT = 12;
  localparam int CR_RESET_BIT   = 2;

  localparam logic [31:0] SR_IDLE_MASK  = 32'd1 << SR_IDLE_BIT;
  localparam logic [31:0] SR_ERR_MASK   = (32'd7) << SR_ERR_LSB;
  localparam logic [31:0] SR_IOC_IRQ    = 32'd1 << SR_IOC_IRQ_BIT;
  localparam logic [31:0] CR_RESET_MASK = 32'd1 << CR_RESET_BIT;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_STATUS  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SA,
    S_WR_SAM,
    S_WR_DA,
    S_WR_DAM,
    S_WR_BTT,
    S_POLL,
    S_CLR,
    S_NEXT,
    S_ERR_RST,
    S_ERR_POLL,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    BM_IDLE,
    BM_WRITE,
    BM_READ
  } bm_state_e;

  // Register-programming order for one chunk; BTT is last and hands over to POLL.
  function automatic state_e next_wr_state(input state_e s);
    case (s)
      S_WR_SA:  return S_WR_SAM;
      S_WR_SAM: return S_WR_DA;
      S_WR_DA:  return S_WR_DAM;
      S_WR_DAM: return S_WR_BTT;
      default:  return S_POLL;
    endcase
  endfunction

endpackage

// File: rtl/cdma_seq_if.sv
// rtl/cdma_seq_if.sv - AXI4-Lite bus toward the CDMA register space
interface cdma_seq_if #(parameter int ADDR_W = 10);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/cdma_seq_axil_single_master.sv
// rtl/cdma_seq_axil_single_master.sv - one AXI4-Lite read or write per start pulse
module axil_single_master
  import cdma_seq_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        resp,
  cdma_seq_if.master        axil
);

  bm_state_e bm_state;

  assign axil.wstrb = 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bm_state     <= BM_IDLE;
      axil.awaddr  <= '0;
      axil.awvalid <= 1'b0;
      axil.wdata   <= '0;
      axil.wvalid  <= 1'b0;
      axil.bready  <= 1'b0;
      axil.araddr  <= '0;
      axil.arvalid <= 1'b0;
      axil.rready  <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      resp         <= '0;
    end else begin
      done <= 1'b0;
      case (bm_state)
        BM_IDLE: begin
          if (start) begin
            if (cmd_write) begin
              axil.awaddr  <= cmd_addr;
              axil.wdata   <= cmd_wdata;
              axil.awvalid <= 1'b1;
              axil.wvalid  <= 1'b1;
              axil.bready  <= 1'b1;
              bm_state     <= BM_WRITE;
            end else begin
              axil.araddr  <= cmd_addr;
              axil.arvalid <= 1'b1;
              axil.rready  <= 1'b1;
              bm_state     <= BM_READ;
            end
          end
        end
        BM_WRITE: begin
          // AW and W retire independently; the slave may take them in either order.
          if (axil.awready) axil.awvalid <= 1'b0;
          if (axil.wready)  axil.wvalid  <= 1'b0;
          if (axil.bvalid) begin
            axil.bready <= 1'b0;
            resp        <= axil.bresp;
            done        <= 1'b1;
            bm_state    <= BM_IDLE;
          end
        end
        BM_READ: begin
          if (axil.arready) axil.arvalid <= 1'b0;
          if (axil.rvalid) begin
            axil.rready <= 1'b0;
            rdata       <= axil.rdata;
            resp        <= axil.rresp;
            done        <= 1'b1;
            bm_state    <= BM_IDLE;
          end
        end
        default: bm_state <= BM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cdma_seq.sv
// rtl/cdma_seq.sv - AXI CDMA simple-mode sequencer: chunked copies, polling, error recovery
// Optional poll watchdog: CDMA_SEQ_TIMEOUT_EN
module cdma_seq
  import cdma_seq_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] MAX_CHUNK      = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_src,
  input  logic [63:0] req_dst,
  input  logic [31:0] req_len,
  output logic        done_valid,
  output logic [1:0]  done_err,
  output logic        busy,
  cdma_seq_if.master  m_axil
);

  if (MAX_CHUNK == 32'd0 || (MAX_CHUNK & (MAX_CHUNK - 32'd1)) != 32'd0 ||
      MAX_CHUNK > 32'h0080_0000 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("cdma_seq: MAX_CHUNK must be a power of two <= 2^23 and TIMEOUT_CYCLES nonzero");
  end

  state_e      state;
  logic [63:0] cur_src;
  logic [63:0] cur_dst;
  logic [31:0] rem;
  logic [31:0] chunk;
  logic [1:0]  err;

  logic              bm_start;
  logic              bm_write;
  logic [ADDR_W-1:0] bm_addr;
  logic [31:0]       bm_wdata;
  logic              bm_done;
  logic [31:0]       bm_rdata;
  logic [1:0]        bm_resp;
  logic              sr_err;
  logic              sr_idle;
  logic              cr_reset;

`ifdef CDMA_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (to_cnt >= TIMEOUT_CYCLES);
`endif

  assign chunk    = (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
  assign done_err = err;
  assign sr_err   = (bm_rdata & SR_ERR_MASK) != 32'd0;
  assign sr_idle  = (bm_rdata & SR_IDLE_MASK) != 32'd0;
  assign cr_reset = (bm_rdata & CR_RESET_MASK) != 32'd0;

  // The bus command is decoded from the state it belongs to; start is pulsed on entry.
  always_comb begin
    bm_write = 1'b1;
    bm_addr  = '0;
    bm_wdata = '0;
    case (state)
      S_WR_SA:    begin bm_addr = ADDR_W'(REG_SA);     bm_wdata = cur_src[31:0];  end
      S_WR_SAM:   begin bm_addr = ADDR_W'(REG_SA_MSB); bm_wdata = cur_src[63:32]; end
      S_WR_DA:    begin bm_addr = ADDR_W'(REG_DA);     bm_wdata = cur_dst[31:0];  end
      S_WR_DAM:   begin bm_addr = ADDR_W'(REG_DA_MSB); bm_wdata = cur_dst[63:32]; end
      S_WR_BTT:   begin bm_addr = ADDR_W'(REG_BTT);    bm_wdata = chunk;          end
      S_POLL:     begin bm_addr = ADDR_W'(REG_SR);     bm_write = 1'b0;           end
      S_CLR:      begin bm_addr = ADDR_W'(REG_SR);     bm_wdata = SR_IOC_IRQ;     end
      S_ERR_RST:  begin bm_addr = ADDR_W'(REG_CR);     bm_wdata = CR_RESET_MASK;  end
      S_ERR_POLL: begin bm_addr = ADDR_W'(REG_CR);     bm_write = 1'b0;           end
      default: ;
    endcase
  end

  axil_single_master #(.ADDR_W(ADDR_W)) u_bm (
    .clk       (clk),
    .reset     (reset),
    .start     (bm_start),
    .cmd_write (bm_write),
    .cmd_addr  (bm_addr),
    .cmd_wdata (bm_wdata),
    .done      (bm_done),
    .rdata     (bm_rdata),
    .resp      (bm_resp),
    .axil      (m_axil)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      err        <= ERR_OK;
      cur_src    <= '0;
      cur_dst    <= '0;
      rem        <= '0;
      bm_start   <= 1'b0;
`ifdef CDMA_SEQ_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      bm_start   <= 1'b0;
      done_valid <= 1'b0;
`ifdef CDMA_SEQ_TIMEOUT_EN
      // Zero outside the poll states, so it starts from zero on every entry.
      if (state == S_POLL || state == S_ERR_POLL) to_cnt <= to_cnt + 32'd1;
      else                                        to_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            err       <= ERR_OK;
            cur_src   <= req_src;
            cur_dst   <= req_dst;
            rem       <= req_len;
            if (req_len == 32'd0) begin
              state      <= S_DONE;
              done_valid <= 1'b1;
            end else begin
              state    <= S_WR_SA;
              bm_start <= 1'b1;
            end
          end
        end
        S_WR_SA, S_WR_SAM, S_WR_DA, S_WR_DAM, S_WR_BTT: begin
          if (bm_done) begin
            bm_start <= 1'b1;
            if (bm_resp != RESP_OKAY) begin
              err   <= ERR_BUS;
              state <= S_ERR_RST;
            end else begin
              state <= next_wr_state(state);
            end
          end
        end
        S_POLL: begin
          if (bm_done) begin
            bm_start <= 1'b1;
            if (bm_resp != RESP_OKAY) begin
              err   <= ERR_BUS;
              state <= S_ERR_RST;
            end else if (sr_err) begin
              err   <= ERR_STATUS;
              state <= S_ERR_RST;
            end else if (sr_idle) begin
              state <= S_CLR;
`ifdef CDMA_SEQ_TIMEOUT_EN
            end else if (to_hit) begin
              err   <= ERR_TIMEOUT;
              state <= S_ERR_RST;
`endif
            end
          end
        end
        S_CLR: begin
          if (bm_done) begin
            if (bm_resp != RESP_OKAY) begin
              err      <= ERR_BUS;
              state    <= S_ERR_RST;
              bm_start <= 1'b1;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          cur_src <= cur_src + {32'd0, chunk};
          cur_dst <= cur_dst + {32'd0, chunk};
          rem     <= rem - chunk;
          if (rem == chunk) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
          end else begin
            state    <= S_WR_SA;
            bm_start <= 1'b1;
          end
        end
        S_ERR_RST: begin
          // Recovery ignores bus responses so the first error code survives.
          if (bm_done) begin
            state    <= S_ERR_POLL;
            bm_start <= 1'b1;
          end
        end
        S_ERR_POLL: begin
          if (bm_done) begin
            if (!cr_reset) begin
              state      <= S_DONE;
              done_valid <= 1'b1;
`ifdef CDMA_SEQ_TIMEOUT_EN
            end else if (to_hit) begin
              err        <= ERR_TIMEOUT;
              state      <= S_DONE;
              done_valid <= 1'b1;
`endif
            end else begin
              bm_start <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
